// File: rtl/pipelined_barrel_shifter.sv
// Two-stage pipelined barrel shifter: SLL, SRL, SRA and ROR with a
// valid/ready stream on both sides and one operation per cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_data, in_amt       operand and shift amount (0..WIDTH-1)
//   in_op                 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid / out_ready output handshake
//   out_data, out_op      shifted result and the mode that produced it
//   out_zero              out_data == 0, registered alongside out_data
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_op,
    output logic             out_zero
);

    // Stage A applies the upper amount bits, stage B the lower ones.
    localparam int LO = SHW / 2;
    localparam int HI = SHW - LO;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic             va;
    logic [WIDTH-1:0] data_a;
    logic [1:0]       op_a;
    logic             sign_a;
    logic [LO-1:0]    amt_lo_a;

    logic             vb;
    logic             en_a;
    logic             en_b;

    logic [SHW-1:0]   amt_hi;
    logic [SHW-1:0]   amt_lo;
    logic [WIDTH-1:0] shifted_a;
    logic [WIDTH-1:0] shifted_b;

    // One partial shift level group. For SRA the fill bit comes from the
    // original operand sign, which stage A carries forward explicitly.
    function automatic logic [WIDTH-1:0] shift_f(
        input logic [WIDTH-1:0] d,
        input logic [SHW-1:0]   amt,
        input logic [1:0]       op,
        input logic             sgn
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        r    = '0;
        fill = ~({WIDTH{1'b1}} >> amt);
        unique case (op)
            OP_SLL: r = d << amt;
            OP_SRL: r = d >> amt;
            OP_SRA: r = (d >> amt) | (sgn ? fill : '0);
            OP_ROR: r = (d >> amt) | (d << (WIDTH - int'(amt)));
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        amt_hi    = {in_amt[SHW-1:LO], {LO{1'b0}}};
        amt_lo    = {{HI{1'b0}}, amt_lo_a};
        shifted_a = shift_f(in_data, amt_hi, in_op, in_data[WIDTH-1]);
        shifted_b = shift_f(data_a, amt_lo, op_a, sign_a);
    end

    assign en_b      = !vb || out_ready;
    assign en_a      = !va || en_b;
    assign in_ready  = en_a;
    assign out_valid = vb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va       <= 1'b0;
            data_a   <= '0;
            op_a     <= OP_SLL;
            sign_a   <= 1'b0;
            amt_lo_a <= '0;
        end else if (en_a) begin
            va <= in_valid;
            if (in_valid) begin
                data_a   <= shifted_a;
                op_a     <= in_op;
                sign_a   <= in_data[WIDTH-1];
                amt_lo_a <= in_amt[LO-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vb       <= 1'b0;
            out_data <= '0;
            out_op   <= OP_SLL;
            out_zero <= 1'b1;
        end else if (en_b) begin
            vb <= va;
            if (va) begin
                out_data <= shifted_b;
                out_op   <= op_a;
                out_zero <= (shifted_b == '0);
            end
        end
    end

endmodule
